// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit-instruction CPU: sequences fetch/decode/execute/writeback,
// owns PC, instruction register and stored ALU flags, and counts retired instructions.
module cpu_ctrl_fsm #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int FLAG_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] ir_q,
  input  logic [FLAG_W-1:0]  alu_flags,
  output logic [FLAG_W-1:0]  flags_q,
  output logic               buf_en,
  output logic               rf_we,
  output logic               mem_sel,
  output logic               dmem_we,
  output logic               dmem_re,
  input  logic               dmem_ready,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEMWR, S_MEMRD, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic imem_req;
    logic buf_en;
    logic rf_we;
    logic mem_sel;
    logic dmem_we;
    logic dmem_re;
    logic halted;
  } outs_t;

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t          state;
  outs_t           outs;
  logic [PC_W-1:0] pc_q;

  // Output pattern registered together with the state it belongs to.
  function automatic outs_t outs_for(input state_t s, input logic from_load);
    outs_t o;
    o = '0;
    case (s)
      S_FETCH: o.imem_req = 1'b1;
      S_EXEC:  o.buf_en   = 1'b1;
      S_MEMWR: o.dmem_we  = 1'b1;
      S_MEMRD: begin
        o.dmem_re = 1'b1;
        o.mem_sel = 1'b1;
      end
      S_WB: begin
        o.buf_en  = 1'b1;
        o.rf_we   = 1'b1;
        o.mem_sel = from_load;
      end
      S_HALT:  o.halted   = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  logic [3:0]      opcode;
  logic [3:0]      op2;
  logic [PC_W+7:0] target_wide;
  logic [PC_W-1:0] target;
  logic            taken;
  state_t          dec_next;

  assign opcode      = ir_q[15:12];
  assign op2         = ir_q[3:0];
  assign target_wide = {{PC_W{1'b0}}, ir_q[11:4]};
  assign target      = target_wide[PC_W-1:0];

  always_comb begin
    taken    = 1'b0;
    dec_next = S_FETCH;
    if (ir_q == '0) begin
      dec_next = S_HALT;
    end else if (opcode[3] || (opcode >= 4'd1 && opcode <= 4'd5)) begin
      dec_next = S_EXEC;
    end else if (opcode == 4'd6) begin
      dec_next = S_MEMWR;
    end else if (opcode == 4'd7) begin
      dec_next = S_MEMRD;
    end else begin
      case (op2)
        4'b1000: taken = 1'b1;
        4'b0100: taken = flags_q[0];
        4'b0101: taken = ~flags_q[0];
        4'b0110: taken = flags_q[1];
        4'b0111: taken = ~flags_q[1];
        default: taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      outs        <= outs_for(S_FETCH, 1'b0);
      pc_q        <= '0;
      ir_q        <= '0;
      flags_q     <= '0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir_q  <= imem_rdata;
            state <= S_DECODE;
            outs  <= outs_for(S_DECODE, 1'b0);
          end
        end
        S_DECODE: begin
          // Branches and NOPs retire here without touching the datapath.
          if (dec_next == S_FETCH) begin
            pc_q        <= taken ? target : pc_q + PC_ONE;
            retired_cnt <= retired_cnt + CNT_ONE;
          end
          state <= dec_next;
          outs  <= outs_for(dec_next, 1'b0);
        end
        S_EXEC: begin
          state <= S_WB;
          outs  <= outs_for(S_WB, 1'b0);
        end
        S_MEMWR: begin
          if (dmem_ready) begin
            pc_q        <= pc_q + PC_ONE;
            retired_cnt <= retired_cnt + CNT_ONE;
            state       <= S_FETCH;
            outs        <= outs_for(S_FETCH, 1'b0);
          end
        end
        S_MEMRD: begin
          if (dmem_ready) begin
            state <= S_WB;
            outs  <= outs_for(S_WB, 1'b1);
          end
        end
        S_WB: begin
          // mem_sel still marks a load here; loads leave the stored flags alone.
          if (!outs.mem_sel) flags_q <= alu_flags;
          pc_q        <= pc_q + PC_ONE;
          retired_cnt <= retired_cnt + CNT_ONE;
          state       <= S_FETCH;
          outs        <= outs_for(S_FETCH, 1'b0);
        end
        default: begin
          state <= S_HALT;
          outs  <= outs_for(S_HALT, 1'b0);
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = outs.imem_req;
  assign buf_en    = outs.buf_en;
  assign rf_we     = outs.rf_we;
  assign mem_sel   = outs.mem_sel;
  assign dmem_we   = outs.dmem_we;
  assign dmem_re   = outs.dmem_re;
  assign halted    = outs.halted;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: walks a short hand-written program through every state.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] ir_q;
  logic [1:0]  alu_flags;
  logic [1:0]  flags_q;
  logic        buf_en, rf_we, mem_sel, dmem_we, dmem_re, dmem_ready, halted;
  logic [15:0] retired_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_ctrl_fsm #(.PC_W(8), .INSTR_W(16), .FLAG_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .ir_q(ir_q), .alu_flags(alu_flags), .flags_q(flags_q),
    .buf_en(buf_en), .rf_we(rf_we), .mem_sel(mem_sel),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_ready(dmem_ready),
    .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH; leaves the DUT in DECODE with instr latched.
  task automatic do_fetch(input logic [15:0] instr, input int waits, input int pc, input int prev_ir);
    chk("fetch_req", 32'(imem_req), 1);
    chk("fetch_addr", 32'(imem_addr), pc);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      tick();
      chk("wait_req", 32'(imem_req), 1);
      chk("wait_addr", 32'(imem_addr), pc);
      chk("wait_ir", 32'(ir_q), prev_ir);
    end
    imem_rdata = instr;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 16'hDEAD;
    chk("ir_load", 32'(ir_q), 32'(instr));
    chk("dec_req", 32'(imem_req), 0);
  endtask

  task automatic alu_op(input logic [15:0] instr, input logic [1:0] fl, input int waits,
                        input int pc, input int prev_ir);
    do_fetch(instr, waits, pc, prev_ir);
    tick();
    chk("exec_buf", 32'(buf_en), 1);
    chk("exec_rfwe", 32'(rf_we), 0);
    alu_flags = fl;
    tick();
    chk("wb_rfwe", 32'(rf_we), 1);
    chk("wb_buf", 32'(buf_en), 1);
    chk("wb_memsel", 32'(mem_sel), 0);
    tick();
    chk("after_wb_rfwe", 32'(rf_we), 0);
    chk("alu_flags_q", 32'(flags_q), 32'(fl));
  endtask

  task automatic br_op(input logic [15:0] instr, input int pc, input int prev_ir,
                       input int exp_pc, input int exp_ret);
    do_fetch(instr, 0, pc, prev_ir);
    tick();
    chk("br_req", 32'(imem_req), 1);
    chk("br_pc", 32'(imem_addr), exp_pc);
    chk("br_ret", 32'(retired_cnt), exp_ret);
    chk("br_rfwe", 32'(rf_we), 0);
  endtask

  initial begin
    rst_n = 1'b1; imem_rdata = 16'h0; imem_valid = 1'b0; alu_flags = 2'b00; dmem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(imem_addr), 0);
    chk("rst_ir", 32'(ir_q), 0);
    chk("rst_flags", 32'(flags_q), 0);
    chk("rst_cnt", 32'(retired_cnt), 0);
    chk("rst_strobes", 32'({buf_en, rf_we, mem_sel, dmem_we, dmem_re, halted}), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_req", 32'(imem_req), 1);
    chk("post_rst_pc", 32'(imem_addr), 0);

    // R-type at 0, sets flags to 01
    alu_op(16'h9014, 2'b01, 0, 'h00, 'h0000);
    chk("alu1_pc", 32'(imem_addr), 'h01);
    chk("alu1_ret", 32'(retired_cnt), 1);
    // flag0 set -> taken to 0x03
    br_op(16'h0034, 'h01, 'h9014, 'h03, 2);
    // flags become 10
    alu_op(16'h1000, 2'b10, 0, 'h03, 'h0034);
    chk("alu2_pc", 32'(imem_addr), 'h04);
    chk("alu2_ret", 32'(retired_cnt), 3);
    // flag0 clear -> not taken
    br_op(16'h0034, 'h04, 'h1000, 'h05, 4);
    // op2 0110 with flag1 set -> taken to 0xA0
    br_op(16'h0A06, 'h05, 'h0034, 'hA0, 5);
    // op2 0011 is a NOP
    br_op(16'h0033, 'hA0, 'h0A06, 'hA1, 6);
    // unconditional jump to 0xFF
    br_op(16'h0FF8, 'hA1, 'h0033, 'hFF, 7);
    // ALU op at 0xFF with two fetch wait cycles; PC wraps
    alu_op(16'hA123, 2'b11, 2, 'hFF, 'h0FF8);
    chk("wrap_pc", 32'(imem_addr), 'h00);
    chk("wrap_ret", 32'(retired_cnt), 8);

    // Load with ready delayed 3 cycles
    do_fetch(16'h7000, 0, 'h00, 'hA123);
    alu_flags = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ld_re", 32'(dmem_re), 1);
      chk("ld_memsel", 32'(mem_sel), 1);
      chk("ld_rfwe", 32'(rf_we), 0);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("ld_wb_rfwe", 32'(rf_we), 1);
    chk("ld_wb_memsel", 32'(mem_sel), 1);
    chk("ld_wb_re", 32'(dmem_re), 0);
    tick();
    chk("ld_done_rfwe", 32'(rf_we), 0);
    chk("ld_flags_kept", 32'(flags_q), 3);
    chk("ld_pc", 32'(imem_addr), 'h01);
    chk("ld_ret", 32'(retired_cnt), 9);

    // Store with immediate ready
    do_fetch(16'h6000, 0, 'h01, 'h7000);
    tick();
    chk("st_we", 32'(dmem_we), 1);
    chk("st_rfwe", 32'(rf_we), 0);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("st_we_done", 32'(dmem_we), 0);
    chk("st_pc", 32'(imem_addr), 'h02);
    chk("st_ret", 32'(retired_cnt), 10);
    chk("st_flags", 32'(flags_q), 3);

    // Reset while a store waits for ready
    do_fetch(16'h6000, 0, 'h02, 'h6000);
    tick();
    tick();
    chk("st2_we_wait", 32'(dmem_we), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(dmem_we), 0);
    chk("midrst_pc", 32'(imem_addr), 0);
    chk("midrst_cnt", 32'(retired_cnt), 0);
    dmem_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rel_req", 32'(imem_req), 1);
    chk("rel_we", 32'(dmem_we), 0);
    chk("rel_pc", 32'(imem_addr), 0);
    chk("rel_cnt", 32'(retired_cnt), 0);
    chk("rel_flags", 32'(flags_q), 0);
    dmem_ready = 1'b0;

    // Halt on 0x0000, then ignore fetch traffic
    do_fetch(16'h0000, 0, 'h00, 'h0000);
    tick();
    chk("halt", 32'(halted), 1);
    chk("halt_req", 32'(imem_req), 0);
    imem_rdata = 16'h9014;
    imem_valid = 1'b1;
    alu_flags  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stay", 32'(halted), 1);
      chk("halt_ir", 32'(ir_q), 0);
      chk("halt_pc", 32'(imem_addr), 0);
      chk("halt_cnt", 32'(retired_cnt), 0);
      chk("halt_strobes", 32'({imem_req, buf_en, rf_we, dmem_we, dmem_re}), 0);
    end
    imem_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
